// File: rtl/i2s_rx.sv
// I2S receiver: oversamples sclk/lrclk/sdin on clk_12_288 and presents complete stereo frames.
// Latency: frame loaded 3 clk_12_288 cycles after the final right-bit sclk rising edge at the pin.
// Backpressure: valid/ready hold; a frame not yet accepted is overwritten and flagged by overrun.
// Optional I2S_RX_ERR_CHECK_EN: slot-length check with frame_err pulse and frame drop.
`timescale 1ns/1ps
module i2s_rx #(
    parameter int DATA_WIDTH = 24,
    parameter int SLOT_WIDTH = 32
) (
    input  logic                  clk_12_288,
    input  logic                  reset_n,
    input  logic                  sclk,
    input  logic                  lrclk,
    input  logic                  sdin,
    output logic [DATA_WIDTH-1:0] left_data,
    output logic [DATA_WIDTH-1:0] right_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  overrun,
    output logic                  frame_err
);
    localparam int CW = $clog2(SLOT_WIDTH + 1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_DATA = CW'(DATA_WIDTH);
`ifdef I2S_RX_ERR_CHECK_EN
    localparam logic [CW-1:0] CNT_SLOT = CW'(SLOT_WIDTH);
`endif

    typedef enum logic [1:0] {SYNC, LEFT, RIGHT} state_t;

    logic [1:0]            sclk_sync;
    logic [1:0]            lrclk_sync;
    logic [1:0]            sdin_sync;
    logic                  sclk_prev;
    logic                  lr_prev;
    state_t                state;
    state_t                state_nxt;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         cnt_nxt;
    logic [CW-1:0]         cnt_inc;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] shreg_nxt;
    logic [DATA_WIDTH-1:0] shift_nxt;
    logic [DATA_WIDTH-1:0] left_hold;
    logic [DATA_WIDTH-1:0] left_hold_nxt;
    logic                  bit_rise;
    logic                  lr_s;
    logic                  sd_s;
    logic                  boundary;
    logic                  frame_done;
`ifdef I2S_RX_ERR_CHECK_EN
    logic                  slot_err;
`endif

    assign bit_rise = sclk_sync[1] & ~sclk_prev;
    assign lr_s     = lrclk_sync[1];
    assign sd_s     = sdin_sync[1];
    assign boundary = bit_rise && (lr_s != lr_prev);
    assign cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);

    // Only slot bit indices below DATA_WIDTH enter the word; padding bits are dropped.
    always_comb begin
        shift_nxt = shreg;
        if (cnt < CNT_DATA) begin
            shift_nxt = (shreg << 1) | DATA_WIDTH'(sd_s);
        end
    end

    always_ff @(posedge clk_12_288 or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync  <= '0;
            lrclk_sync <= '0;
            sdin_sync  <= '0;
            sclk_prev  <= 1'b0;
            lr_prev    <= 1'b0;
            state      <= SYNC;
            cnt        <= '0;
            shreg      <= '0;
            left_hold  <= '0;
        end else begin
            sclk_sync  <= {sclk_sync[0], sclk};
            lrclk_sync <= {lrclk_sync[0], lrclk};
            sdin_sync  <= {sdin_sync[0], sdin};
            sclk_prev  <= sclk_sync[1];
            if (bit_rise) begin
                lr_prev <= lr_s;
            end
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            shreg     <= shreg_nxt;
            left_hold <= left_hold_nxt;
        end
    end

    // The edge that first shows a new lrclk level carries the last bit of the ending slot.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        shreg_nxt     = shreg;
        left_hold_nxt = left_hold;
        frame_done    = 1'b0;
`ifdef I2S_RX_ERR_CHECK_EN
        slot_err      = 1'b0;
`endif
        if (bit_rise) begin
            case (state)
                SYNC: begin
                    if (lr_prev && !lr_s) begin
                        state_nxt = LEFT;
                    end
                end
                LEFT, RIGHT: begin
                    cnt_nxt   = cnt_inc;
                    shreg_nxt = shift_nxt;
                    if (boundary) begin
                        cnt_nxt   = '0;
                        shreg_nxt = '0;
`ifdef I2S_RX_ERR_CHECK_EN
                        if (cnt_inc != CNT_SLOT) begin
                            slot_err  = 1'b1;
                            state_nxt = lr_s ? SYNC : LEFT;
                        end else if (state == LEFT) begin
                            left_hold_nxt = shift_nxt;
                            state_nxt     = RIGHT;
                        end else begin
                            frame_done = 1'b1;
                            state_nxt  = LEFT;
                        end
`else
                        if (state == LEFT) begin
                            left_hold_nxt = shift_nxt;
                            state_nxt     = RIGHT;
                        end else begin
                            frame_done = 1'b1;
                            state_nxt  = LEFT;
                        end
`endif
                    end
                end
                default: state_nxt = SYNC;
            endcase
        end
    end

    // Outputs change only on a completed frame, so partial words never appear.
    always_ff @(posedge clk_12_288 or negedge reset_n) begin
        if (!reset_n) begin
            left_data  <= '0;
            right_data <= '0;
            out_valid  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (frame_done) begin
                left_data  <= left_hold;
                right_data <= shift_nxt;
                out_valid  <= 1'b1;
                overrun    <= out_valid && !out_ready;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef I2S_RX_ERR_CHECK_EN
    always_ff @(posedge clk_12_288 or negedge reset_n) begin
        if (!reset_n) begin
            frame_err <= 1'b0;
        end else begin
            frame_err <= slot_err;
        end
    end
`else
    assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_rx.sv
// Randomized bench for i2s_rx: drives I2S bit streams at the pins and compares frames
// against the values sent, with slot-length rules applied by a simple delivery model.
`timescale 1ns/1ps
module tb_i2s_rx;
    localparam int      DW        = 24;
    localparam int      SW        = 32;
    localparam realtime CLK_HALF  = 40.690;
    localparam realtime SCLK_HALF = 162.760;

    logic          clk_12_288 = 1'b0;
    logic          reset_n    = 1'b0;
    logic          sclk       = 1'b1;
    logic          lrclk      = 1'b1;
    logic          sdin       = 1'b0;
    logic          out_ready  = 1'b0;
    logic [DW-1:0] left_data;
    logic [DW-1:0] right_data;
    logic          out_valid;
    logic          overrun;
    logic          frame_err;

    int   n_cmp       = 0;
    int   n_bad       = 0;
    int   valid_rises = 0;
    int   ovr_cnt     = 0;
    int   ferr_cnt    = 0;
    int   lat         = 0;
    logic prev_v      = 1'b0;

    i2s_rx #(.DATA_WIDTH(DW), .SLOT_WIDTH(SW)) dut (
        .clk_12_288 (clk_12_288),
        .reset_n    (reset_n),
        .sclk       (sclk),
        .lrclk      (lrclk),
        .sdin       (sdin),
        .left_data  (left_data),
        .right_data (right_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .overrun    (overrun),
        .frame_err  (frame_err)
    );

    initial forever #(CLK_HALF) clk_12_288 = ~clk_12_288;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Event counters observed one step after each active edge.
    initial forever begin
        @(posedge clk_12_288);
        #1;
        if (out_valid && !prev_v) valid_rises++;
        if (overrun) ovr_cnt++;
        if (frame_err) ferr_cnt++;
        prev_v = out_valid;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic align();
        @(posedge clk_12_288);
        #13;
    endtask

    // Bit j of a slot of length len: lrclk flips on the last bit; bits past DW are random padding.
    task automatic send_bits(input logic [DW-1:0] w, input int len, input logic lr,
                             input int from, input int to);
        for (int j = from; j <= to; j++) begin
            #(SCLK_HALF);
            sclk  = 1'b0;
            lrclk = (j == len - 1) ? ~lr : lr;
            sdin  = (j < DW) ? w[DW-1-j] : 1'($urandom);
            #(SCLK_HALF);
            sclk = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r,
                              input int ll, input int rl);
        align();
        send_bits(l, ll, 1'b0, 0, ll - 1);
        send_bits(r, rl, 1'b1, 0, rl - 1);
    endtask

    // Called right at the final right-bit rising edge; out_valid must be low beforehand.
    task automatic expect_load(input logic [DW-1:0] l, input logic [DW-1:0] r, output int cyc);
        cyc = 0;
        while (cyc < 8) begin
            @(posedge clk_12_288);
            cyc++;
            #1;
            if (out_valid) break;
        end
        chk("load_valid", out_valid, 1);
        chk("load_latency_le4", cyc <= 4, 1);
        chk("load_left", left_data, l);
        chk("load_right", right_data, r);
    endtask

    task automatic expect_drop();
        @(posedge clk_12_288);
        #1;
        chk("valid_drop_after_accept", out_valid, 0);
    endtask

    initial begin
        int            c;
        int            v0;
        int            o0;
        int            f0;
        logic [DW-1:0] l;
        logic [DW-1:0] r;
        logic [DW-1:0] l2;
        logic [DW-1:0] r2;

        #5;
        chk("rst_left", left_data, 0);
        chk("rst_right", right_data, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_frame_err", frame_err, 0);

        // Leave reset in the middle of a right slot.
        align();
        r = DW'($urandom);
        send_bits(r, SW, 1'b1, 0, 9);
        reset_n = 1'b1;
        send_bits(r, SW, 1'b1, 10, SW - 1);
        repeat (6) @(posedge clk_12_288);
        #1;
        chk("startup_no_valid", valid_rises, 0);

        out_ready = 1'b1;
        send_frame(24'hA5A5A5, 24'h5A5A5A, SW, SW);
        expect_load(24'hA5A5A5, 24'h5A5A5A, lat);
        expect_drop();
        chk("startup_single_valid", valid_rises, 1);

        for (int k = 0; k < 6; k++) begin
            l = DW'($urandom);
            r = DW'($urandom);
            send_frame(l, r, SW, SW);
            expect_load(l, r, c);
            expect_drop();
        end

        // Two frames without acceptance.
        out_ready = 1'b0;
        o0 = ovr_cnt;
        send_frame(24'h000001, 24'h000002, SW, SW);
        expect_load(24'h000001, 24'h000002, c);
        send_frame(24'h000003, 24'h000004, SW, SW);
        repeat (6) @(posedge clk_12_288);
        #1;
        chk("bp_overrun_once", ovr_cnt - o0, 1);
        chk("bp_valid_held", out_valid, 1);
        chk("bp_left", left_data, 24'h000003);
        chk("bp_right", right_data, 24'h000004);
        out_ready = 1'b1;
        expect_drop();
        out_ready = 1'b0;

        // out_ready raised only for the cycle in which frame 2 loads.
        l = DW'($urandom);
        r = DW'($urandom);
        send_frame(l, r, SW, SW);
        expect_load(l, r, c);
        l2 = DW'($urandom);
        r2 = DW'($urandom);
        o0 = ovr_cnt;
        send_frame(l2, r2, SW, SW);
        if (lat <= 1) out_ready = 1'b1;
        for (int k = 1; k <= lat; k++) begin
            @(posedge clk_12_288);
            #1;
            if (k == lat - 1) out_ready = 1'b1;
        end
        out_ready = 1'b0;
        chk("simul_valid", out_valid, 1);
        chk("simul_left", left_data, l2);
        chk("simul_right", right_data, r2);
        repeat (3) @(posedge clk_12_288);
        #1;
        chk("simul_no_overrun", ovr_cnt - o0, 0);
        chk("simul_valid_kept", out_valid, 1);
        out_ready = 1'b1;
        expect_drop();

        // Short left slot.
        v0 = valid_rises;
        f0 = ferr_cnt;
        l = DW'($urandom);
        r = DW'($urandom);
        send_frame(l, r, SW - 1, SW);
        repeat (8) @(posedge clk_12_288);
        #1;
`ifdef I2S_RX_ERR_CHECK_EN
        chk("short_frame_err_pulse", ferr_cnt - f0, 1);
        chk("short_frame_dropped", valid_rises - v0, 0);
`else
        chk("short_no_frame_err", ferr_cnt - f0, 0);
        chk("short_frame_delivered", valid_rises - v0, 1);
        chk("short_left", left_data, l);
        chk("short_right", right_data, r);
`endif
        send_frame(24'h123456, 24'h654321, SW, SW);
        expect_load(24'h123456, 24'h654321, c);
        expect_drop();

        // Reset during a right slot while a frame is held.
        out_ready = 1'b0;
        send_frame(24'hFFFFFF, 24'hC0FFEE, SW, SW);
        expect_load(24'hFFFFFF, 24'hC0FFEE, c);
        align();
        l = DW'($urandom);
        r = DW'($urandom);
        send_bits(l, SW, 1'b0, 0, SW - 1);
        send_bits(r, SW, 1'b1, 0, 9);
        reset_n = 1'b0;
        #1;
        chk("midrst_left", left_data, 0);
        chk("midrst_right", right_data, 0);
        chk("midrst_valid", out_valid, 0);
        chk("midrst_overrun", overrun, 0);
        chk("midrst_frame_err", frame_err, 0);
        send_bits(r, SW, 1'b1, 10, 19);
        reset_n = 1'b1;
        v0 = valid_rises;
        send_bits(r, SW, 1'b1, 20, SW - 1);
        repeat (6) @(posedge clk_12_288);
        #1;
        chk("midrst_partial_discarded", valid_rises - v0, 0);
        out_ready = 1'b1;
        l = DW'($urandom);
        r = DW'($urandom);
        send_frame(l, r, SW, SW);
        expect_load(l, r, c);
        expect_drop();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/i2s_rx.md
I2S_RX -- requirements
Module: i2s_rx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 24: sample bits captured per channel, MSB first.
REQ-002 SHALL have parameter SLOT_WIDTH, default 32: sclk periods per channel; SLOT_WIDTH >= DATA_WIDTH, SLOT_WIDTH <= 64.
REQ-003 SHALL have port clk_12_288, input, 1: system clock, 12.288 MHz.
REQ-004 SHALL have port reset_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port sclk, input, 1: external I2S bit clock, asynchronous to clk_12_288, frequency <= clk_12_288/4.
REQ-006 SHALL have port lrclk, input, 1: external word select; 0 = left, 1 = right.
REQ-007 SHALL have port sdin, input, 1: serial data; changes on sclk falling edge.
REQ-008 SHALL have port left_data, output, DATA_WIDTH: last complete left sample.
REQ-009 SHALL have port right_data, output, DATA_WIDTH: last complete right sample.
REQ-010 SHALL have port out_valid, output, 1: a stereo frame is held in left_data/right_data.
REQ-011 SHALL have port out_ready, input, 1: consumer accepts the frame when out_valid && out_ready.
REQ-012 SHALL have port overrun, output, 1: one-cycle pulse when an unaccepted frame is overwritten.
REQ-013 SHALL have port frame_err, output, 1: one-cycle pulse on a slot-length violation.

Function
REQ-014 SHALL pass sclk, lrclk and sdin through two-flop synchronizers; all logic runs on clk_12_288 only.
REQ-015 SHALL detect an sclk rising edge as synchronized sclk = 1 with previous value 0; lrclk and sdin are sampled on that same cycle.
REQ-016 SHALL implement FSM SYNC -> LEFT -> RIGHT -> LEFT ...; SYNC exits to LEFT only on the first sampled lrclk 1->0 transition; bits seen in SYNC are discarded.
REQ-017 SHALL treat the rising edge at which a sampled lrclk change is first seen as the last bit (index SLOT_WIDTH-1) of the ending slot; the next rising edge is MSB (index 0) of the new slot.
REQ-018 SHALL shift bit indices 0..DATA_WIDTH-1 MSB-first into the channel word; indices DATA_WIDTH..SLOT_WIDTH-1 are ignored.
REQ-019 SHALL maintain a saturating per-slot bit counter (width ceil(log2(SLOT_WIDTH+1))), cleared after each slot boundary.
REQ-020 SHALL complete a frame at the lrclk 0->1 ... 1->0 boundary ending the RIGHT slot, provided the preceding LEFT slot completed.
REQ-021 SHALL load left_data, right_data and set out_valid no more than 4 clk_12_288 cycles after the final right bit's sclk rising edge at the pin.
REQ-022 SHALL hold out_valid high and data stable until out_valid && out_ready, then deassert out_valid next cycle.
REQ-023 SHALL, when a new frame completes while out_valid=1 and out_ready=0, overwrite the data, keep out_valid=1, and pulse overrun for 1 cycle.
REQ-024 SHALL, when a new frame completes in the same cycle as out_valid && out_ready, load the new frame, keep out_valid=1, and not pulse overrun.
REQ-025 SHALL not expose partially shifted words on left_data/right_data.

Reset
REQ-026 SHALL, on reset_n=0, immediately clear synchronizers, counter, shift registers, left_data=0, right_data=0, out_valid=0, overrun=0, frame_err=0 and set FSM to SYNC.
REQ-027 SHALL, on reset mid-frame, discard the partial frame and resynchronize on the next lrclk 1->0 transition.

Configuration
REQ-028 SHALL, with macro I2S_RX_ERR_CHECK_EN defined, check at each slot boundary that the counted bits equal SLOT_WIDTH; on mismatch it pulses frame_err for 1 cycle, drops the current frame, and returns to LEFT on a 1->0 boundary or to SYNC otherwise.
REQ-029 SHALL, without I2S_RX_ERR_CHECK_EN, tie frame_err to 0, omit the check logic, and deliver frames regardless of slot length.

Verification
REQ-030 SHALL test the basic frame: sclk=3.072 MHz, SLOT_WIDTH=32; send L=0xA5A5A5, R=0x5A5A5A -> one out_valid with left_data=0xA5A5A5, right_data=0x5A5A5A, with out_ready=1 and within 4 cycles.
REQ-031 SHALL test backpressure: out_ready=0 for 2 frames (0x000001/0x000002, then 0x000003/0x000004) -> overrun pulses once, data shows 0x000003/0x000004, out_valid stays 1.
REQ-032 SHALL test simultaneous accept and load: out_ready=1 asserted exactly on the load cycle of frame 2 -> no overrun, frame 2 data valid.
REQ-033 SHALL test startup mid-frame: release reset while lrclk=1 mid right slot -> first out_valid only after a full L+R frame that follows a 1->0 transition.
REQ-034 SHALL test a short slot with I2S_RX_ERR_CHECK_EN defined: left slot of 31 bits -> frame_err pulses and that frame produces no out_valid; the next correct frame 0x123456/0x654321 is delivered.
REQ-035 SHALL test reset mid-frame: assert reset_n=0 during the right slot -> all outputs 0 immediately; the next full frame is delivered correctly.
